// File: rtl/imem_loader_pkg.sv
// Shared widths, instruction-memory geometry, frame sync marker and loader FSM
// state encodings for the Y86 instruction-memory loader.
`ifndef IMEM_LOADER_DEFINES
`define IMEM_LOADER_DEFINES
`define D_WORD 64
`define BYTE 8
`define NIBBLE 4
`endif

package imem_loader_pkg;

  localparam int          IMEM_BYTES = 1024;
  localparam int          IMEM_AW    = 10;
  localparam logic [15:0] IMEM_LIMIT = 16'd1024;
  localparam logic [7:0]  LOAD_SYNC  = 8'hA5;
  localparam int          FETCH_BYTES = 10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR_H = 3'd1,
    S_ADDR_L = 3'd2,
    S_LEN_H  = 3'd3,
    S_LEN_L  = 3'd4,
    S_DATA   = 3'd5,
    S_CHK    = 3'd6,
    S_DONE   = 3'd7
  } load_state_t;

endpackage

// File: rtl/imem_ram.sv
// 1024x8 instruction storage: one synchronous byte write port and a ten-byte
// combinational fetch window where bytes beyond the end of memory read as zero.
module imem_ram
  import imem_loader_pkg::*;
(
  input  logic                           clk_i,
  input  logic                           wr_en_i,
  input  logic [IMEM_AW-1:0]             wr_addr_i,
  input  logic [`BYTE-1:0]               wr_data_i,
  input  logic [`D_WORD-1:0]             rd_addr_i,
  output logic [FETCH_BYTES*`BYTE-1:0]   rd_instr_o,
  output logic                           rd_error_o
);

  logic [`BYTE-1:0] mem [IMEM_BYTES];

  // Contents are deliberately never reset so code survives a loader reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
  end

  // A 65-bit sum keeps fetches near the top of the 64-bit space from wrapping
  // back into valid memory.
  for (genvar k = 0; k < FETCH_BYTES; k++) begin : g_rd
    logic [`D_WORD:0] byteAddr;
    assign byteAddr = {1'b0, rd_addr_i} + 65'(k);
    assign rd_instr_o[(FETCH_BYTES-1-k)*`BYTE +: `BYTE] =
      (byteAddr < 65'(IMEM_BYTES)) ? mem[byteAddr[IMEM_AW-1:0]] : '0;
  end

  assign rd_error_o = rd_addr_i > 64'(IMEM_BYTES - 1);

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream writer for the Y86 instruction memory plus fetch read port.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module imem_loader
  import imem_loader_pkg::*;
(
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         load_valid_i,
  input  logic [`BYTE-1:0]             load_data_i,
  output logic                         load_ready_o,
  output logic                         load_busy_o,
  output logic                         load_done_o,
  output logic                         load_err_o,
  output logic                         cpu_hold_o,
  input  logic [`D_WORD-1:0]           rd_addr_i,
  output logic [FETCH_BYTES*`BYTE-1:0] rd_instr_o,
  output logic                         rd_error_o
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam load_state_t DATA_END = S_CHK;
  logic [`BYTE-1:0] acc_q;
`else
  localparam load_state_t DATA_END = S_DONE;
`endif

  load_state_t state_q;
  logic [15:0] addr_q;
  logic [15:0] count_q;
  logic        err_q;
  logic        accept;
  logic        inRange;
  logic        wrEn;

  assign load_ready_o = !rst_i && (state_q != S_DONE);
  assign load_busy_o  = state_q != S_IDLE;
  assign load_done_o  = state_q == S_DONE;
  assign load_err_o   = err_q;
  assign cpu_hold_o   = load_busy_o;

  assign accept  = load_valid_i && load_ready_o;
  assign inRange = addr_q < IMEM_LIMIT;
  assign wrEn    = (state_q == S_DATA) && accept && inRange;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      acc_q   <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: if (accept && load_data_i == LOAD_SYNC) begin
          err_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          acc_q   <= '0;
`endif
          state_q <= S_ADDR_H;
        end
        S_ADDR_H: if (accept) begin
          addr_q[15:8] <= load_data_i;
          state_q      <= S_ADDR_L;
        end
        S_ADDR_L: if (accept) begin
          addr_q[7:0] <= load_data_i;
          state_q     <= S_LEN_H;
        end
        S_LEN_H: if (accept) begin
          count_q[15:8] <= load_data_i;
          state_q       <= S_LEN_L;
        end
        S_LEN_L: if (accept) begin
          count_q[7:0] <= load_data_i;
          state_q      <= ({count_q[15:8], load_data_i} == 16'd0) ? DATA_END : S_DATA;
        end
        // Out-of-range bytes still advance the address and count so the frame
        // length stays honoured; only the write itself is dropped.
        S_DATA: if (accept) begin
          if (!inRange) err_q <= 1'b1;
          addr_q  <= addr_q + 16'd1;
          count_q <= count_q - 16'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          acc_q   <= acc_q ^ load_data_i;
`endif
          if (count_q == 16'd1) state_q <= DATA_END;
        end
        S_CHK: if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (load_data_i != acc_q) err_q <= 1'b1;
`endif
          state_q <= S_DONE;
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  imem_ram u_ram (
    .clk_i      (clk_i),
    .wr_en_i    (wrEn),
    .wr_addr_i  (addr_q[IMEM_AW-1:0]),
    .wr_data_i  (load_data_i),
    .rd_addr_i  (rd_addr_i),
    .rd_instr_o (rd_instr_o),
    .rd_error_o (rd_error_o)
  );

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; sends CHK bytes only when
// IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        load_valid_i;
  logic [7:0]  load_data_i;
  logic        load_ready_o;
  logic        load_busy_o;
  logic        load_done_o;
  logic        load_err_o;
  logic        cpu_hold_o;
  logic [63:0] rd_addr_i;
  logic [79:0] rd_instr_o;
  logic        rd_error_o;

  int checks = 0;
  int errors = 0;

  imem_loader dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .load_valid_i (load_valid_i),
    .load_data_i  (load_data_i),
    .load_ready_o (load_ready_o),
    .load_busy_o  (load_busy_o),
    .load_done_o  (load_done_o),
    .load_err_o   (load_err_o),
    .cpu_hold_o   (cpu_hold_o),
    .rd_addr_i    (rd_addr_i),
    .rd_instr_o   (rd_instr_o),
    .rd_error_o   (rd_error_o)
  );

  always #5 clk_i = ~clk_i;

  // Compares one observation against a hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [79:0] observed, input logic [79:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Presents one byte and holds it until the loader has accepted it.
  task automatic applyStimulus(input logic [7:0] b);
    int guard;
    guard = 0;
    load_valid_i = 1'b1;
    load_data_i  = b;
    while (!load_ready_o && guard < 20) begin
      @(posedge clk_i); #1;
      guard++;
    end
    if (guard >= 20) checkOutput("ready_timeout", 80'(load_ready_o), 80'd1);
    @(posedge clk_i); #1;
    load_valid_i = 1'b0;
  endtask

  task automatic sendChk(input logic [7:0] b);
`ifdef IMEM_LOADER_CHECKSUM_EN
    applyStimulus(b);
`else
    if (b === 8'hxx) $display("[TB] unreachable");
`endif
  endtask

  task automatic idleCycle();
    @(posedge clk_i); #1;
  endtask

  task automatic readTop(input logic [63:0] a);
    rd_addr_i = a;
    #1;
  endtask

  initial begin
    rst_i = 1'b1;
    load_valid_i = 1'b0;
    load_data_i = 8'h00;
    rd_addr_i = 64'd0;

    // Reset state
    @(posedge clk_i); @(posedge clk_i); #1;
    checkOutput("rst_ready", 80'(load_ready_o), 80'd0);
    checkOutput("rst_busy",  80'(load_busy_o),  80'd0);
    checkOutput("rst_done",  80'(load_done_o),  80'd0);
    checkOutput("rst_err",   80'(load_err_o),   80'd0);
    checkOutput("rst_hold",  80'(cpu_hold_o),   80'd0);
    rst_i = 1'b0;
    #1;
    checkOutput("post_rst_ready", 80'(load_ready_o), 80'd1);

    // Clean frame at 0x0010
    applyStimulus(8'hA5);
    checkOutput("a_busy", 80'(load_busy_o), 80'd1);
    checkOutput("a_hold", 80'(cpu_hold_o),  80'd1);
    applyStimulus(8'h00); applyStimulus(8'h10);
    applyStimulus(8'h00); applyStimulus(8'h03);
    applyStimulus(8'h30); applyStimulus(8'hF2); applyStimulus(8'h0A);
    sendChk(8'hC8);
    checkOutput("a_done",      80'(load_done_o),  80'd1);
    checkOutput("a_done_rdy",  80'(load_ready_o), 80'd0);
    idleCycle();
    checkOutput("a_done_end",  80'(load_done_o),  80'd0);
    checkOutput("a_busy_end",  80'(load_busy_o),  80'd0);
    checkOutput("a_err",       80'(load_err_o),   80'd0);
    readTop(64'd16);
    checkOutput("a_mem16", 80'(rd_instr_o[79:56]), 80'h30F20A);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Same frame, bad checksum into 0x0020
    applyStimulus(8'hA5); applyStimulus(8'h00); applyStimulus(8'h20);
    applyStimulus(8'h00); applyStimulus(8'h03);
    applyStimulus(8'h30); applyStimulus(8'hF2); applyStimulus(8'h0A);
    applyStimulus(8'h00);
    idleCycle(); idleCycle();
    checkOutput("chk_err", 80'(load_err_o), 80'd1);
    readTop(64'd32);
    checkOutput("chk_mem32", 80'(rd_instr_o[79:56]), 80'h30F20A);
`endif

    // Frame straddling the end of memory
    applyStimulus(8'hA5); applyStimulus(8'h03); applyStimulus(8'hFE);
    applyStimulus(8'h00); applyStimulus(8'h04);
    applyStimulus(8'h11); applyStimulus(8'h22); applyStimulus(8'h33); applyStimulus(8'h44);
    sendChk(8'h44);
    idleCycle(); idleCycle(); idleCycle();
    checkOutput("oor_err_sticky", 80'(load_err_o), 80'd1);
    readTop(64'd1022);
    checkOutput("oor_mem1022", rd_instr_o, 80'h1122_0000_0000_0000_0000);

    // Fill 1020..1021; SYNC must clear the sticky error
    applyStimulus(8'hA5);
    checkOutput("sync_clears_err", 80'(load_err_o), 80'd0);
    applyStimulus(8'h03); applyStimulus(8'hFC);
    applyStimulus(8'h00); applyStimulus(8'h02);
    applyStimulus(8'hAB); applyStimulus(8'hCD);
    sendChk(8'h66);
    idleCycle();
    checkOutput("top_err", 80'(load_err_o), 80'd0);
    readTop(64'd1020);
    checkOutput("rd1020",     rd_instr_o, 80'hABCD_1122_0000_0000_0000);
    checkOutput("rd1020_err", 80'(rd_error_o), 80'd0);
    readTop(64'd1023);
    checkOutput("rd1023_err", 80'(rd_error_o), 80'd0);
    readTop(64'd1024);
    checkOutput("rd1024_err",   80'(rd_error_o), 80'd1);
    checkOutput("rd1024_instr", rd_instr_o, 80'd0);

    // Garbage before SYNC and gapped data into 0x0040
    applyStimulus(8'h00); applyStimulus(8'hFF); applyStimulus(8'h5A);
    checkOutput("garbage_busy", 80'(load_busy_o), 80'd0);
    applyStimulus(8'hA5); applyStimulus(8'h00); applyStimulus(8'h40);
    applyStimulus(8'h00); applyStimulus(8'h03);
    applyStimulus(8'h30); idleCycle();
    checkOutput("gap_hold1", 80'(cpu_hold_o), 80'd1);
    applyStimulus(8'hF2); idleCycle();
    checkOutput("gap_hold2", 80'(cpu_hold_o), 80'd1);
    applyStimulus(8'h0A);
    sendChk(8'hC8);
    checkOutput("gap_done", 80'(load_done_o), 80'd1);
    checkOutput("gap_hold3", 80'(cpu_hold_o), 80'd1);
    idleCycle();
    checkOutput("gap_err", 80'(load_err_o), 80'd0);
    readTop(64'd64);
    checkOutput("gap_mem64", 80'(rd_instr_o[79:56]), 80'h30F20A);

    // Zero-length frame
    applyStimulus(8'hA5); applyStimulus(8'h00); applyStimulus(8'h00);
    applyStimulus(8'h00); applyStimulus(8'h00);
    sendChk(8'h00);
    checkOutput("len0_done", 80'(load_done_o), 80'd1);
    idleCycle();
    checkOutput("len0_err", 80'(load_err_o), 80'd0);

    // Reset after two data bytes of a four-byte frame
    applyStimulus(8'hA5); applyStimulus(8'h00); applyStimulus(8'h80);
    applyStimulus(8'h00); applyStimulus(8'h04);
    applyStimulus(8'hDE); applyStimulus(8'hAD);
    rst_i = 1'b1;
    idleCycle();
    rst_i = 1'b0;
    #1;
    checkOutput("midrst_busy",  80'(load_busy_o),  80'd0);
    checkOutput("midrst_ready", 80'(load_ready_o), 80'd1);
    readTop(64'd128);
    checkOutput("midrst_mem", 80'(rd_instr_o[79:64]), 80'hDEAD);
    applyStimulus(8'hA5); applyStimulus(8'h00); applyStimulus(8'h80);
    applyStimulus(8'h00); applyStimulus(8'h04);
    applyStimulus(8'h01); applyStimulus(8'h02); applyStimulus(8'h03); applyStimulus(8'h04);
    sendChk(8'h04);
    checkOutput("reload_done", 80'(load_done_o), 80'd1);
    idleCycle();
    checkOutput("reload_err", 80'(load_err_o), 80'd0);
    readTop(64'd128);
    checkOutput("reload_mem", 80'(rd_instr_o[79:48]), 80'h01020304);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Writer side of the Y86 instruction memory. Accepts a framed byte stream from a host/testbench and writes it into the 1024-byte instruction memory. Also provides the 10-byte-wide combinational read port that the fetch stage uses to pull instructions at `f_pc`. While a frame is in progress, `cpu_hold_o` holds the pipeline so fetch never sees partially loaded code.

## Interface
- `MEM_BYTES`, 1024: instruction memory size in bytes; addresses `0..MEM_BYTES-1`.
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `clk_i`  in  1  single clock, all state on rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `load_valid_i`  in  1  host byte valid.
- `load_data_i`  in  8  host byte.
- `load_ready_o`  out  1  loader can accept a byte; transfer occurs when `load_valid_i && load_ready_o`.
- `load_busy_o`  out  1  a frame is in progress (any state other than IDLE).
- `load_done_o`  out  1  one-cycle pulse at end of frame.
- `load_err_o`  out  1  sticky error for the last frame.
- `cpu_hold_o`  out  1  equals `load_busy_o`; used to stall fetch.
- `rd_addr_i`  in  64  fetch PC.
- `rd_instr_o`  out  80  bytes `mem[rd_addr_i+0..+9]`; byte 0 in `[79:72]`, byte 9 in `[7:0]`.
- `rd_error_o`  out  1  `rd_addr_i > MEM_BYTES-1`.

## Operation
- Frame format: SYNC, ADDR_H, ADDR_L, LEN_H, LEN_L, LEN data bytes, CHK.
  - Start address is 16-bit, big-endian.
  - LEN is 16-bit, big-endian.
  - CHK is the XOR of all data bytes.
- FSM states: IDLE, ADDR_H, ADDR_L, LEN_H, LEN_L, DATA, CHK, DONE.
- IDLE:
  - Accepted bytes other than SYNC_BYTE are discarded.
  - Accepting SYNC_BYTE clears `load_err_o`, clears the checksum accumulator and moves to ADDR_H.
- ADDR_H → ADDR_L → LEN_H → LEN_L: one accepted byte each, latched into the 16-bit address and count registers.
- Leaving LEN_L: LEN == 0 goes to CHK; otherwise goes to DATA.
- DATA, per accepted byte:
  - If address < MEM_BYTES, write `mem[addr] <= byte`; otherwise suppress the write and set the error flag.
  - Then `addr += 1` (16-bit, no wrap to 0 within the memory), XOR the byte into the accumulator, and `count -= 1`.
  - When count reaches 0, go to CHK.
- CHK: on the accepted byte, set `load_err_o` if byte != accumulator; go to DONE.
- DONE: one cycle with `load_ready_o = 0` and `load_done_o = 1`, then IDLE.
- A checksum error does not roll back bytes already written.
- Read port: purely combinational.
  - Any byte address ≥ MEM_BYTES reads as 8'h00.
  - `rd_instr_o` is valid regardless of loader state.

## Timing
- Reset values:
  - state IDLE;
  - `load_ready_o` 0 during the reset cycle, 1 from the first cycle after reset;
  - `load_busy_o`, `load_done_o`, `load_err_o`, `cpu_hold_o` all 0;
  - address, count and accumulator 0;
  - memory contents not cleared.
- One byte per cycle maximum. `load_ready_o = 1` in every state except DONE.
- Write latency: a byte accepted at edge N is visible on `rd_instr_o` after edge N (same-cycle read returns the old value).
- `load_busy_o` rises the cycle after SYNC is accepted and falls when the FSM re-enters IDLE. `load_done_o` pulses during DONE.
- Minimum frame time: header (5) + LEN + CHK (1) + DONE (1) cycles.
- Gaps in `load_valid_i` stall the FSM indefinitely; there is no timeout.
- `rst_i` mid-frame: FSM returns to IDLE, the partial frame is abandoned, and bytes already written remain.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN`:
  - Defined: CHK state and XOR accumulator are present, as above.
  - Undefined: no CHK byte is expected. DATA (or LEN_L when LEN == 0) goes directly to DONE, and `load_err_o` reflects only out-of-range writes.

## Structure
- Shared package/defines carry:
  - the existing `D_WORD` / `BYTE` / `NIBBLE` width macros;
  - IMEM size (1024);
  - LOAD_SYNC (8'hA5);
  - the FSM state encodings.
- One sub-module, `imem_ram`:
  - 1024×8 storage, one synchronous write port, ten combinational byte read ports with out-of-range-reads-as-zero;
  - the fetch-side read logic is reused from it.

## Test plan
- Reset, then frame A5 00 10 00 03 30 F2 0A, plus CHK 0xC8 (when `IMEM_LOADER_CHECKSUM_EN` is defined) → `mem[16..18]` = 30 F2 0A; `load_done_o` one pulse; `load_err_o` = 0; `rd_addr_i` = 16 gives `rd_instr_o[79:56]` = 30F20A.
- Same frame with CHK 0x00 → data still written; `load_err_o` = 1 until the next SYNC.
- Frame A5 03 FE 00 04 11 22 33 44 CHK → `mem[1022]` = 11, `mem[1023]` = 22, remaining writes suppressed, `load_err_o` = 1.
- Garbage bytes 00 FF 5A before SYNC, and `load_valid_i` toggled every other cycle during DATA → identical result to the clean frame; `cpu_hold_o` high throughout the frame.
- `rst_i` asserted after the 2nd data byte of a 4-byte frame → FSM in IDLE, first 2 bytes present, `load_busy_o` = 0; the next full frame loads correctly.
- `rd_addr_i` = 1020 → bytes 1020..1023 from memory, lower 6 bytes 00, `rd_error_o` = 0; `rd_addr_i` = 1024 → `rd_error_o` = 1, `rd_instr_o` = 0.
